cim_tile_responder: RTL and testbench

- Behavioural crossbar-tile responder: the CIM-side end of the fc_layer row-write / column-read interface.
- Latches per-row input values written by the layer, runs a serial MAC scan on start, holds busy for a fixed latency, then serves saturated column results by read address.
- Used in perf-sim tops and benches in place of the analog tile, so layer controllers can be exercised cycle-accurately.
- Fixed weight pattern: w(r,c)=1 when r%2 == c%2, else 0.

---
 rtl/cim_tile_responder.sv | 143 ++++++++++++++
 tb/tb_cim_tile_responder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_tile_responder.sv
`timescale 1ns/1ps
// Behavioural CIM crossbar-tile stand-in: row writes, serial even/odd MAC scan, saturated column reads.
// Optional macro CIM_TILE_OP_COUNT_EN adds a 16-bit completed-compute counter output o_op_count.
module cim_tile_responder #(
    parameter int datatype_size = 2,
    parameter int xbar_size     = 512,
    parameter int extra_latency = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cim_we,
    input  logic [$clog2(xbar_size)-1:0] i_cim_wr_addr,
    input  logic [datatype_size-1:0]     i_cim_data,
    input  logic                         i_cim_start,
    output logic                         o_cim_busy,
    input  logic [$clog2(xbar_size)-1:0] i_cim_rd_addr,
    output logic [datatype_size-1:0]     o_cim_rd_data
`ifdef CIM_TILE_OP_COUNT_EN
    ,
    output logic [15:0]                  o_op_count
`endif
);
    localparam int AW    = $clog2(xbar_size);
    localparam int ACC_W = datatype_size + AW;
    localparam int LW    = (extra_latency > 1) ? $clog2(extra_latency) : 1;

    localparam logic [datatype_size-1:0] DMAX      = '1;
    localparam logic [AW-1:0]            CNT_LAST  = '1;
    localparam logic [LW-1:0]            WAIT_LAST = LW'((extra_latency > 0) ? extra_latency - 1 : 0);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

    state_t                   r_state;
    logic                     r_busy;
    logic [AW-1:0]            r_cnt;
    logic [LW-1:0]            r_wait;
    logic [ACC_W-1:0]         r_acc_even;
    logic [ACC_W-1:0]         r_acc_odd;
    logic [datatype_size-1:0] r_res_even;
    logic [datatype_size-1:0] r_res_odd;
    logic [datatype_size-1:0] r_rd_data;
    logic [datatype_size-1:0] r_row_buf [xbar_size];

    logic [ACC_W-1:0]         w_row_ext;
    logic [datatype_size-1:0] w_sat_even;
    logic [datatype_size-1:0] w_sat_odd;

    // Weight pattern w(r,c)=1 iff parities match: every even column sees the even-row sum.
    assign w_row_ext  = {{AW{1'b0}}, r_row_buf[r_cnt]};
    assign w_sat_even = (r_acc_even > {{AW{1'b0}}, DMAX}) ? DMAX : r_acc_even[datatype_size-1:0];
    assign w_sat_odd  = (r_acc_odd  > {{AW{1'b0}}, DMAX}) ? DMAX : r_acc_odd[datatype_size-1:0];

    // Writes only land while idle; a write coincident with start is seen by the scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < xbar_size; i++) begin
                r_row_buf[i] <= '0;
            end
        end else if (r_state == IDLE && i_cim_we) begin
            r_row_buf[i_cim_wr_addr] <= i_cim_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_wait     <= '0;
            r_acc_even <= '0;
            r_acc_odd  <= '0;
            r_res_even <= '0;
            r_res_odd  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cim_start) begin
                        r_acc_even <= '0;
                        r_acc_odd  <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_cnt[0]) begin
                        r_acc_odd <= r_acc_odd + w_row_ext;
                    end else begin
                        r_acc_even <= r_acc_even + w_row_ext;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_wait  <= '0;
                        r_state <= (extra_latency > 0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                DONE: begin
                    r_res_even <= w_sat_even;
                    r_res_odd  <= w_sat_odd;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= i_cim_rd_addr[0] ? r_res_odd : r_res_even;
        end
    end

    assign o_cim_busy    = r_busy;
    assign o_cim_rd_data = r_rd_data;

`ifdef CIM_TILE_OP_COUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_count <= '0;
        end else if (r_state == DONE) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign o_op_count = r_op_count;
`endif

endmodule

// File: tb/tb_cim_tile_responder.sv
`timescale 1ns/1ps
// Directed self-checking bench for cim_tile_responder at default parameters.
module tb_cim_tile_responder;
    localparam int DW   = 2;
    localparam int XB   = 512;
    localparam int LAT  = 4;
    localparam int AW   = $clog2(XB);
    localparam int BUSY = XB + LAT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_cim_we = 1'b0;
    logic [AW-1:0] i_cim_wr_addr = '0;
    logic [DW-1:0] i_cim_data = '0;
    logic          i_cim_start = 1'b0;
    logic          o_cim_busy;
    logic [AW-1:0] i_cim_rd_addr = '0;
    logic [DW-1:0] o_cim_rd_data;
`ifdef CIM_TILE_OP_COUNT_EN
    logic [15:0]   o_op_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    cim_tile_responder #(
        .datatype_size(DW),
        .xbar_size    (XB),
        .extra_latency(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cim_we     (i_cim_we),
        .i_cim_wr_addr(i_cim_wr_addr),
        .i_cim_data   (i_cim_data),
        .i_cim_start  (i_cim_start),
        .o_cim_busy   (o_cim_busy),
        .i_cim_rd_addr(i_cim_rd_addr),
        .o_cim_rd_data(o_cim_rd_data)
`ifdef CIM_TILE_OP_COUNT_EN
        ,
        .o_op_count   (o_op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input int data);
        i_cim_we      = 1'b1;
        i_cim_wr_addr = AW'(addr);
        i_cim_data    = DW'(data);
        tick();
        i_cim_we      = 1'b0;
    endtask

    task automatic fill_rows(input int data);
        for (int r = 0; r < XB; r++) write_row(r, data);
    endtask

    task automatic do_read(input int addr, output logic [DW-1:0] data);
        i_cim_rd_addr = AW'(addr);
        tick();
        data = o_cim_rd_data;
        $display("read  addr %0d -> %0d", addr, data);
    endtask

    // Pulses start and returns the number of sampled cycles with busy high (bounded).
    task automatic start_and_wait(output int n);
        i_cim_start = 1'b1;
        tick();
        i_cim_start = 1'b0;
        n = 0;
        while (o_cim_busy && n < 2000) begin
            n++;
            tick();
        end
        $display("start busy for %0d cycles", n);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (o_cim_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", o_cim_busy);
        end
        vectors++;
        if (o_cim_rd_data !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_rd_data: got %0d want 0", o_cim_rd_data);
        end
        rst = 1'b1;
        tick();
        do_read(5, d);
        vectors++;
        if (d !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_read5: got %0d want 0", d);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        int n;
        int addrs [4] = '{0, 1, 2, 511};
        logic [DW-1:0] exp [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        write_row(0, 1);
        write_row(1, 2);
        start_and_wait(n);
        vectors++;
        if (n != BUSY) begin
            miscompares++;
            $display("FAIL basic_busy_len: got %0d want %0d", n, BUSY);
        end
        for (int k = 0; k < 4; k++) begin
            do_read(addrs[k], d);
            vectors++;
            if (d !== exp[k]) begin
                miscompares++;
                $display("FAIL basic_read%0d: got %0d want %0d", addrs[k], d, exp[k]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] d;
        int n;
        fill_rows(3);
        start_and_wait(n);
        vectors++;
        if (n != BUSY) begin
            miscompares++;
            $display("FAIL sat_busy_len: got %0d want %0d", n, BUSY);
        end
        for (int a = 0; a < 2; a++) begin
            do_read(a, d);
            vectors++;
            if (d !== 2'd3) begin
                miscompares++;
                $display("FAIL sat_read%0d: got %0d want 3", a, d);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [DW-1:0] d;
        int n;
        fill_rows(0);
        i_cim_start = 1'b1;
        tick();
        i_cim_start = 1'b0;
        n = 0;
        while (o_cim_busy && n < 2000) begin
            n++;
            if (n == 100) begin
                i_cim_we      = 1'b1;
                i_cim_wr_addr = '0;
                i_cim_data    = 2'd3;
                i_cim_start   = 1'b1;
            end
            tick();
            i_cim_we    = 1'b0;
            i_cim_start = 1'b0;
        end
        $display("start busy for %0d cycles (write+start injected)", n);
        vectors++;
        if (n != BUSY) begin
            miscompares++;
            $display("FAIL ignore_busy_len: got %0d want %0d", n, BUSY);
        end
        tick();
        vectors++;
        if (o_cim_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_restart: busy got %b want 0", o_cim_busy);
        end
        do_read(0, d);
        vectors++;
        if (d !== 2'd0) begin
            miscompares++;
            $display("FAIL ignore_read0: got %0d want 0", d);
        end
        start_and_wait(n);
        do_read(0, d);
        vectors++;
        if (d !== 2'd0) begin
            miscompares++;
            $display("FAIL ignore_rescan_read0: got %0d want 0", d);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] d;
        int n;
        i_cim_we      = 1'b1;
        i_cim_wr_addr = AW'(4);
        i_cim_data    = 2'd1;
        i_cim_start   = 1'b1;
        tick();
        i_cim_we    = 1'b0;
        i_cim_start = 1'b0;
        n = 0;
        while (o_cim_busy && n < 2000) begin
            n++;
            tick();
        end
        $display("write row4 + start busy for %0d cycles", n);
        vectors++;
        if (n != BUSY) begin
            miscompares++;
            $display("FAIL same_busy_len: got %0d want %0d", n, BUSY);
        end
        do_read(0, d);
        vectors++;
        if (d !== 2'd1) begin
            miscompares++;
            $display("FAIL same_read0: got %0d want 1", d);
        end
        do_read(1, d);
        vectors++;
        if (d !== 2'd0) begin
            miscompares++;
            $display("FAIL same_read1: got %0d want 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        int n;
        write_row(1, 3);
        i_cim_start = 1'b1;
        tick();
        i_cim_start = 1'b0;
        repeat (200) tick();
        rst = 1'b0;
        #1;
        $display("reset asserted mid-scan");
        vectors++;
        if (o_cim_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_busy: got %b want 0", o_cim_busy);
        end
        vectors++;
        if (o_cim_rd_data !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_rd_data: got %0d want 0", o_cim_rd_data);
        end
        tick();
        rst = 1'b1;
        tick();
        do_read(0, d);
        vectors++;
        if (d !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_read0: got %0d want 0", d);
        end
        start_and_wait(n);
        vectors++;
        if (n != BUSY) begin
            miscompares++;
            $display("FAIL midrst_busy_len: got %0d want %0d", n, BUSY);
        end
        for (int a = 0; a < 2; a++) begin
            do_read(a, d);
            vectors++;
            if (d !== 2'd0) begin
                miscompares++;
                $display("FAIL midrst_empty_read%0d: got %0d want 0", a, d);
            end
        end
    endtask

`ifdef CIM_TILE_OP_COUNT_EN
    task automatic test_op_count();
        int n;
        start_and_wait(n);
        start_and_wait(n);
        vectors++;
        if (o_op_count !== 16'd3) begin
            miscompares++;
            $display("FAIL op_count_3: got %0d want 3", o_op_count);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (o_op_count !== 16'd0) begin
            miscompares++;
            $display("FAIL op_count_reset: got %0d want 0", o_op_count);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_busy_ignore();
        test_same_cycle();
        test_reset_mid();
`ifdef CIM_TILE_OP_COUNT_EN
        test_op_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
